rv_bus_arb: RTL

//  Shares one memory bus port between the fetch unit (read-only) and the LSU (read/write).

---
 rtl/rv_bus_arb_if.sv | 56 +++++
 rtl/rv_bus_arb.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rv_bus_arb_if.sv
// Signal bundle for rv_bus_arb: fetch port, LSU port, pipeline redirect and the shared
// memory bus port.
//   slave  : seen from the arbiter (takes requests and bus responses, drives acks,
//            valids, read data and the bus address phase)
//   master : seen from the environment (requesters and bus model)
interface rv_bus_arb_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // pipeline redirect
    logic                  i_pc_change;
    // fetch port
    logic                  i_inst_req;
    logic [ADDR_W-1:0]     i_inst_addr;
    logic                  o_inst_ack;
    logic                  o_inst_valid;
    logic [DATA_W-1:0]     o_inst_data;
    // LSU port
    logic                  i_data_req;
    logic [ADDR_W-1:0]     i_data_addr;
    logic                  i_data_we;
    logic [DATA_W/8-1:0]   i_data_be;
    logic [DATA_W-1:0]     i_data_wdata;
    logic                  o_data_ack;
    logic                  o_data_valid;
    logic [DATA_W-1:0]     o_data_rdata;
    // memory bus port
    logic                  o_bus_req;
    logic [ADDR_W-1:0]     o_bus_addr;
    logic                  o_bus_we;
    logic [DATA_W/8-1:0]   o_bus_be;
    logic [DATA_W-1:0]     o_bus_wdata;
    logic                  i_bus_ack;
    logic                  i_bus_valid;
    logic [DATA_W-1:0]     i_bus_rdata;

    modport slave (
        input  i_pc_change,
        input  i_inst_req, i_inst_addr,
        output o_inst_ack, o_inst_valid, o_inst_data,
        input  i_data_req, i_data_addr, i_data_we, i_data_be, i_data_wdata,
        output o_data_ack, o_data_valid, o_data_rdata,
        output o_bus_req, o_bus_addr, o_bus_we, o_bus_be, o_bus_wdata,
        input  i_bus_ack, i_bus_valid, i_bus_rdata
    );

    modport master (
        output i_pc_change,
        output i_inst_req, i_inst_addr,
        input  o_inst_ack, o_inst_valid, o_inst_data,
        output i_data_req, i_data_addr, i_data_we, i_data_be, i_data_wdata,
        input  o_data_ack, o_data_valid, o_data_rdata,
        input  o_bus_req, o_bus_addr, o_bus_we, o_bus_be, o_bus_wdata,
        output i_bus_ack, i_bus_valid, i_bus_rdata
    );
endinterface

// File: rtl/rv_bus_arb.sv
// rv_bus_arb: shares one memory bus port between the fetch unit (read-only) and the LSU.
// One outstanding transaction at a time (IDLE -> ADDR -> RESP -> IDLE). Data wins
// arbitration unless fetch has waited through STARVE_LIMIT consecutive data grants.
// A pipeline redirect drops the response of an in-flight fetch.
// Ports:
//   i_clk    : clock, rising edge
//   i_reset  : synchronous reset, active-high
//   bus      : rv_bus_arb_if.slave (fetch, LSU, redirect and memory bus signals)
module rv_bus_arb #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic         i_clk,
    input logic         i_reset,
    rv_bus_arb_if.slave bus
);
    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StAddr, StResp} state_e;
    typedef enum logic {OwnInst, OwnData} owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              bus_req_q, bus_req_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_we_q, bus_we_d;
    logic [BE_W-1:0]   bus_be_q, bus_be_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

    logic grant_inst, grant_data, complete;
    logic inst_ack, data_ack, inst_valid, data_valid;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        drop_d      = drop_q;
        starve_d    = starve_q;
        bus_req_d   = bus_req_q;
        bus_addr_d  = bus_addr_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        grant_inst  = 1'b0;
        grant_data  = 1'b0;
        complete    = 1'b0;
        inst_ack    = 1'b0;
        data_ack    = 1'b0;
        inst_valid  = 1'b0;
        data_valid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                grant_inst = bus.i_inst_req & ~bus.i_pc_change &
                             (~bus.i_data_req | (starve_q == LIMIT));
                grant_data = ~grant_inst & bus.i_data_req;
                if (grant_inst) begin
                    owner_d     = OwnInst;
                    bus_addr_d  = bus.i_inst_addr;
                    bus_we_d    = 1'b0;
                    bus_be_d    = '1;
                    bus_wdata_d = '0;
                    bus_req_d   = 1'b1;
                    state_d     = StAddr;
                end else if (grant_data) begin
                    owner_d     = OwnData;
                    bus_addr_d  = bus.i_data_addr;
                    bus_we_d    = bus.i_data_we;
                    bus_be_d    = bus.i_data_be;
                    bus_wdata_d = bus.i_data_wdata;
                    bus_req_d   = 1'b1;
                    state_d     = StAddr;
                end
            end
            StAddr: begin
                if (bus.i_bus_ack) begin
                    inst_ack  = (owner_q == OwnInst);
                    data_ack  = (owner_q == OwnData);
                    bus_req_d = 1'b0;
                    complete  = bus.i_bus_valid;
                    state_d   = bus.i_bus_valid ? StIdle : StResp;
                end
            end
            StResp: begin
                if (bus.i_bus_valid) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A redirect in the valid cycle itself must already suppress the response.
        if (complete) begin
            inst_valid = (owner_q == OwnInst) & ~(drop_q | bus.i_pc_change);
            data_valid = (owner_q == OwnData);
        end

        if ((owner_q == OwnInst) && (state_q != StIdle) && bus.i_pc_change) begin
            drop_d = 1'b1;
        end
        if (state_d == StIdle) begin
            drop_d = 1'b0;
        end

        if (!bus.i_inst_req || grant_inst) begin
            starve_d = '0;
        end else if (grant_data && (starve_q != LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StIdle;
            owner_q     <= OwnInst;
            drop_q      <= 1'b0;
            starve_q    <= '0;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            drop_q      <= drop_d;
            starve_q    <= starve_d;
            bus_req_q   <= bus_req_d;
            bus_addr_q  <= bus_addr_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign bus.o_bus_req    = bus_req_q;
    assign bus.o_bus_addr   = bus_addr_q;
    assign bus.o_bus_we     = bus_we_q;
    assign bus.o_bus_be     = bus_be_q;
    assign bus.o_bus_wdata  = bus_wdata_q;
    assign bus.o_inst_ack   = inst_ack;
    assign bus.o_data_ack   = data_ack;
    assign bus.o_inst_valid = inst_valid;
    assign bus.o_data_valid = data_valid;
    assign bus.o_inst_data  = bus.i_bus_rdata;
    assign bus.o_data_rdata = bus.i_bus_rdata;
endmodule
